// File: rtl/rf_wb_arbiter_pkg.sv
// Shared types for the register-file write-back path: data/select widths and the
// {sel, data} entry carried by the ALU FIFO and the output stage.
package rf_wb_arbiter_pkg;

   localparam int REG_W = 16;
   localparam int SEL_W = 3;

   typedef struct packed {
      logic [SEL_W-1:0] sel;
      logic [REG_W-1:0] data;
   } wb_entry_t;

   localparam int ENTRY_W = $bits(wb_entry_t);

endpackage

// File: rtl/wb_fifo.sv
// Circular buffer for queued ALU write-backs; the head is readable combinationally, and pop/push take effect at the clock edge.
// The owner never pushes when full. entries_o/valid_o give an age-ordered view (slot 0 = head) for the forwarding search.
module wb_fifo
   import rf_wb_arbiter_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push_i,
   input  logic [ENTRY_W-1:0]         push_entry_i,
   input  logic                       pop_i,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [ENTRY_W-1:0]         head_o,
   output logic [DEPTH*ENTRY_W-1:0]   entries_o,
   output logic [DEPTH-1:0]           valid_o
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [ENTRY_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]   head_q, head_d;
   logic [PTR_W-1:0]   tail_q, tail_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               do_push, do_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      if (p == PTR_W'(DEPTH - 1)) return '0;
      return p + PTR_W'(1);
   endfunction

   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign empty_o = (count_q == '0);
   assign head_o  = mem_q[head_q];
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (do_push) tail_d = ptr_inc(tail_q);
      if (do_pop)  head_d = ptr_inc(head_q);
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         if (do_push) mem_q[tail_q] <= push_entry_i;
      end
   end

   // Rotate storage so slot k is the k-th oldest entry, independent of pointer position.
   for (genvar k = 0; k < DEPTH; k++) begin : g_age
      logic [PTR_W:0]   sum;
      logic [PTR_W-1:0] slot;
      assign sum  = {1'b0, head_q} + (PTR_W+1)'(k);
      assign slot = (sum >= (PTR_W+1)'(DEPTH)) ? PTR_W'(sum - (PTR_W+1)'(DEPTH))
                                                : sum[PTR_W-1:0];
      assign entries_o[k*ENTRY_W +: ENTRY_W] = mem_q[slot];
      assign valid_o[k] = (count_q > CNT_W'(k));
   end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Merges un-stallable load returns and FIFO-buffered ALU results onto the single register-file write port.
// One cycle from selection to write; loads always win. ALU side is valid/ready; forwarding covers every uncommitted write.
module rf_wb_arbiter
   import rf_wb_arbiter_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        alu_valid,
   output logic        alu_ready,
   input  logic [2:0]  alu_reg,
   input  logic [15:0] alu_data,
   input  logic        ld_valid,
   input  logic [2:0]  ld_reg,
   input  logic [15:0] ld_data,
   output logic        write,
   output logic [2:0]  writeregsel,
   output logic [15:0] writedata,
   input  logic [2:0]  q1sel,
   input  logic [2:0]  q2sel,
   output logic        q1hit,
   output logic        q2hit,
   output logic [15:0] q1data,
   output logic [15:0] q2data,
   output logic        err
);

   logic                     fifo_full, fifo_empty;
   logic [ENTRY_W-1:0]       fifo_head;
   logic [DEPTH*ENTRY_W-1:0] fifo_entries;
   logic [DEPTH-1:0]         fifo_valid;
   logic                     fifo_push, fifo_pop;
   logic                     alu_acc, bypass, hazard;
   wb_entry_t                head_e, hz_e, fwd_e;

   logic               write_q, write_d;
   logic [SEL_W-1:0]   sel_q, sel_d;
   logic [REG_W-1:0]   data_q, data_d;
   logic               err_q, err_d;

   wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk          (clk),
      .rst          (rst),
      .push_i       (fifo_push),
      .push_entry_i ({alu_reg, alu_data}),
      .pop_i        (fifo_pop),
      .full_o       (fifo_full),
      .empty_o      (fifo_empty),
      .head_o       (fifo_head),
      .entries_o    (fifo_entries),
      .valid_o      (fifo_valid)
   );

   assign alu_ready   = ~fifo_full;
   assign alu_acc     = alu_valid & ~fifo_full;
   assign head_e      = fifo_head;
   assign write       = write_q;
   assign writeregsel = sel_q;
   assign writedata   = data_q;
   assign err         = err_q;

   always_comb begin
      write_d  = 1'b0;
      sel_d    = sel_q;
      data_d   = data_q;
      fifo_pop = 1'b0;
      bypass   = 1'b0;
      if (ld_valid) begin
         write_d = 1'b1;
         sel_d   = ld_reg;
         data_d  = ld_data;
      end else if (!fifo_empty) begin
         write_d  = 1'b1;
         sel_d    = head_e.sel;
         data_d   = head_e.data;
         fifo_pop = 1'b1;
      end else if (alu_acc) begin
         write_d = 1'b1;
         sel_d   = alu_reg;
         data_d  = alu_data;
         bypass  = 1'b1;
      end
      fifo_push = alu_acc & ~bypass;
   end

   always_comb begin
      hz_e   = '0;
      hazard = 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
         hz_e = fifo_entries[k*ENTRY_W +: ENTRY_W];
         if (ld_valid && fifo_valid[k] && (hz_e.sel == ld_reg)) hazard = 1'b1;
      end
      err_d = err_q | (alu_valid & fifo_full) | hazard;
   end

   // Output stage is oldest, then FIFO head..tail; later matches overwrite so the youngest wins.
   always_comb begin
      fwd_e  = '0;
      q1hit  = write_q && (sel_q == q1sel);
      q1data = q1hit ? data_q : '0;
      q2hit  = write_q && (sel_q == q2sel);
      q2data = q2hit ? data_q : '0;
      for (int k = 0; k < DEPTH; k++) begin
         fwd_e = fifo_entries[k*ENTRY_W +: ENTRY_W];
         if (fifo_valid[k] && (fwd_e.sel == q1sel)) begin
            q1hit  = 1'b1;
            q1data = fwd_e.data;
         end
         if (fifo_valid[k] && (fwd_e.sel == q2sel)) begin
            q2hit  = 1'b1;
            q2data = fwd_e.data;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         write_q <= 1'b0;
         sel_q   <= '0;
         data_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         write_q <= write_d;
         sel_q   <= sel_d;
         data_q  <= data_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: vector table with hand-computed ready/forwarding/err values,
// plus a reference queue model whose predicted writes are scored against the write port.
module tb_rf_wb_arbiter;

   localparam int DEPTH = 2;

   typedef struct packed {
      logic [2:0]  sel;
      logic [15:0] data;
   } ent_t;

   typedef struct {
      logic        lv;
      logic [2:0]  lr;
      logic [15:0] ld;
      logic        av;
      logic [2:0]  ar;
      logic [15:0] ad;
      logic [2:0]  s1;
      logic [2:0]  s2;
      logic        rdy;
      logic        h1;
      logic [15:0] d1;
      logic        h2;
      logic [15:0] d2;
      logic        er;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        alu_valid, alu_ready;
   logic [2:0]  alu_reg;
   logic [15:0] alu_data;
   logic        ld_valid;
   logic [2:0]  ld_reg;
   logic [15:0] ld_data;
   logic        write;
   logic [2:0]  writeregsel;
   logic [15:0] writedata;
   logic [2:0]  q1sel, q2sel;
   logic        q1hit, q2hit;
   logic [15:0] q1data, q2data;
   logic        err;

   int   checks = 0;
   int   errors = 0;
   ent_t mq[$];
   ent_t sb[$];
   logic m_err;
   logic m_wr;
   vec_t tbl[21];
   logic rdy_s;

   rf_wb_arbiter #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_reg(alu_reg), .alu_data(alu_data),
      .ld_valid(ld_valid), .ld_reg(ld_reg), .ld_data(ld_data),
      .write(write), .writeregsel(writeregsel), .writedata(writedata),
      .q1sel(q1sel), .q2sel(q2sel), .q1hit(q1hit), .q2hit(q2hit),
      .q1data(q1data), .q2data(q2data), .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual %0h required %0h", nm, act, exp);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      sb.delete();
      m_err = 1'b0;
      m_wr  = 1'b0;
   endtask

   task automatic model_step(input logic lv, input logic [2:0] lr, input logic [15:0] ldd,
                             input logic av, input logic [2:0] ar, input logic [15:0] ad);
      logic rdy, acc;
      ent_t e;
      rdy = (mq.size() < DEPTH);
      acc = av && rdy;
      if (av && !rdy) m_err = 1'b1;
      if (lv) foreach (mq[i]) if (mq[i].sel == lr) m_err = 1'b1;
      m_wr = 1'b1;
      if (lv) e = '{sel: lr, data: ldd};
      else if (mq.size() > 0) e = mq.pop_front();
      else if (acc) begin
         e = '{sel: ar, data: ad};
         acc = 1'b0;
      end else begin
         e = '0;
         m_wr = 1'b0;
      end
      if (acc) mq.push_back('{sel: ar, data: ad});
      if (m_wr) sb.push_back(e);
   endtask

   task automatic monitor();
      ent_t e;
      if (m_wr) begin
         e = sb.pop_front();
         chk("write_en", 32'(write), 32'd1);
         chk("write_sel", 32'(writeregsel), 32'(e.sel));
         chk("write_data", 32'(writedata), 32'(e.data));
      end else begin
         chk("write_idle", 32'(write), 32'd0);
      end
      chk("err_model", 32'(err), 32'(m_err));
   endtask

   task automatic cyc(input logic lv, input logic [2:0] lr, input logic [15:0] ldd,
                      input logic av, input logic [2:0] ar, input logic [15:0] ad,
                      input logic [2:0] s1, input logic [2:0] s2, output logic rdy);
      @(negedge clk);
      ld_valid = lv; ld_reg = lr; ld_data = ldd;
      alu_valid = av; alu_reg = ar; alu_data = ad;
      q1sel = s1; q2sel = s2;
      #1;
      rdy = alu_ready;
      model_step(lv, lr, ldd, av, ar, ad);
      @(posedge clk);
      #1;
      monitor();
   endtask

   task automatic idle(input logic [2:0] s1);
      logic r;
      cyc(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, s1, 3'd0, r);
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_write"}, 32'(write), 32'd0);
      chk({tag, "_sel"}, 32'(writeregsel), 32'd0);
      chk({tag, "_data"}, 32'(writedata), 32'd0);
      chk({tag, "_err"}, 32'(err), 32'd0);
      chk({tag, "_ready"}, 32'(alu_ready), 32'd1);
      chk({tag, "_q1hit"}, 32'(q1hit), 32'd0);
      chk({tag, "_q1data"}, 32'(q1data), 32'd0);
      chk({tag, "_q2hit"}, 32'(q2hit), 32'd0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      ld_valid = 1'b0; alu_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   initial begin
      //            lv  lr    ld        av  ar    ad        s1    s2    rdy h1  d1        h2  d2        er
      tbl[0]  = '{1'b0, 3'd0, 16'h0000, 1'b1, 3'd3, 16'h1234, 3'd3, 3'd0, 1'b1, 1'b1, 16'h1234, 1'b0, 16'h0000, 1'b0};
      tbl[1]  = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 3'd3, 3'd0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0};
      tbl[2]  = '{1'b1, 3'd5, 16'hBEEF, 1'b1, 3'd2, 16'h0042, 3'd2, 3'd5, 1'b1, 1'b1, 16'h0042, 1'b1, 16'hBEEF, 1'b0};
      tbl[3]  = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 3'd2, 3'd5, 1'b1, 1'b1, 16'h0042, 1'b0, 16'h0000, 1'b0};
      tbl[4]  = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 3'd2, 3'd5, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0};
      tbl[5]  = '{1'b1, 3'd7, 16'h7000, 1'b1, 3'd1, 16'h0011, 3'd1, 3'd7, 1'b1, 1'b1, 16'h0011, 1'b1, 16'h7000, 1'b0};
      tbl[6]  = '{1'b1, 3'd7, 16'h7001, 1'b1, 3'd2, 16'h0022, 3'd2, 3'd1, 1'b1, 1'b1, 16'h0022, 1'b1, 16'h0011, 1'b0};
      tbl[7]  = '{1'b1, 3'd7, 16'h7002, 1'b0, 3'd0, 16'h0000, 3'd1, 3'd7, 1'b0, 1'b1, 16'h0011, 1'b1, 16'h7002, 1'b0};
      tbl[8]  = '{1'b1, 3'd7, 16'h7003, 1'b0, 3'd0, 16'h0000, 3'd4, 3'd2, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0022, 1'b0};
      tbl[9]  = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 3'd1, 3'd2, 1'b0, 1'b1, 16'h0011, 1'b1, 16'h0022, 1'b0};
      tbl[10] = '{1'b0, 3'd0, 16'h0000, 1'b1, 3'd3, 16'h0033, 3'd3, 3'd2, 1'b1, 1'b1, 16'h0033, 1'b1, 16'h0022, 1'b0};
      tbl[11] = '{1'b0, 3'd0, 16'h0000, 1'b1, 3'd4, 16'h0044, 3'd4, 3'd3, 1'b1, 1'b1, 16'h0044, 1'b1, 16'h0033, 1'b0};
      tbl[12] = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 3'd4, 3'd3, 1'b1, 1'b1, 16'h0044, 1'b0, 16'h0000, 1'b0};
      tbl[13] = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 3'd4, 3'd3, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0};
      tbl[14] = '{1'b1, 3'd5, 16'h0555, 1'b1, 3'd6, 16'h0001, 3'd6, 3'd5, 1'b1, 1'b1, 16'h0001, 1'b1, 16'h0555, 1'b0};
      tbl[15] = '{1'b1, 3'd6, 16'h0003, 1'b1, 3'd6, 16'h0002, 3'd5, 3'd6, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0002, 1'b1};
      tbl[16] = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 3'd6, 3'd0, 1'b0, 1'b1, 16'h0002, 1'b0, 16'h0000, 1'b1};
      tbl[17] = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 3'd6, 3'd0, 1'b1, 1'b1, 16'h0002, 1'b0, 16'h0000, 1'b1};
      tbl[18] = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 3'd6, 3'd0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1};
      tbl[19] = '{1'b0, 3'd0, 16'h0000, 1'b1, 3'd0, 16'h00A0, 3'd0, 3'd6, 1'b1, 1'b1, 16'h00A0, 1'b0, 16'h0000, 1'b1};
      tbl[20] = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 3'd0, 3'd6, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1};

      rst = 1'b1;
      alu_valid = 1'b0; alu_reg = 3'd0; alu_data = 16'h0;
      ld_valid = 1'b0; ld_reg = 3'd0; ld_data = 16'h0;
      q1sel = 3'd0; q2sel = 3'd0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      check_reset_vals("por");
      rst = 1'b0;

      for (int i = 0; i < 21; i++) begin
         cyc(tbl[i].lv, tbl[i].lr, tbl[i].ld, tbl[i].av, tbl[i].ar, tbl[i].ad,
             tbl[i].s1, tbl[i].s2, rdy_s);
         chk($sformatf("v%0d_ready", i), 32'(rdy_s), 32'(tbl[i].rdy));
         chk($sformatf("v%0d_q1hit", i), 32'(q1hit), 32'(tbl[i].h1));
         chk($sformatf("v%0d_q1data", i), 32'(q1data), 32'(tbl[i].d1));
         chk($sformatf("v%0d_q2hit", i), 32'(q2hit), 32'(tbl[i].h2));
         chk($sformatf("v%0d_q2data", i), 32'(q2data), 32'(tbl[i].d2));
         chk($sformatf("v%0d_err", i), 32'(err), 32'(tbl[i].er));
      end

      // Overflow: offer while full must be dropped and latch err.
      do_reset();
      chk("ovf_err_clear", 32'(err), 32'd0);
      cyc(1'b1, 3'd7, 16'h0701, 1'b1, 3'd1, 16'h0101, 3'd0, 3'd0, rdy_s);
      cyc(1'b1, 3'd7, 16'h0702, 1'b1, 3'd2, 16'h0202, 3'd0, 3'd0, rdy_s);
      cyc(1'b0, 3'd0, 16'h0000, 1'b1, 3'd3, 16'hDEAD, 3'd3, 3'd0, rdy_s);
      chk("ovf_ready", 32'(rdy_s), 32'd0);
      chk("ovf_err_set", 32'(err), 32'd1);
      for (int i = 0; i < 4; i++) begin
         idle(3'd3);
         chk($sformatf("ovf_nodead%0d", i), 32'(write && writedata == 16'hDEAD), 32'd0);
         chk($sformatf("ovf_q3miss%0d", i), 32'(q1hit), 32'd0);
      end
      chk("ovf_err_sticky", 32'(err), 32'd1);

      // Asynchronous reset with two entries queued and a write in flight.
      do_reset();
      cyc(1'b1, 3'd7, 16'h0711, 1'b1, 3'd1, 16'h0111, 3'd1, 3'd0, rdy_s);
      cyc(1'b1, 3'd7, 16'h0722, 1'b1, 3'd2, 16'h0222, 3'd1, 3'd7, rdy_s);
      chk("pre_rst_full", 32'(alu_ready), 32'd0);
      @(negedge clk);
      ld_valid = 1'b0; alu_valid = 1'b0;
      rst = 1'b1;
      #1;
      check_reset_vals("mid");
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      for (int i = 0; i < 3; i++) begin
         idle(3'd1);
         chk($sformatf("post_rst_q1hit%0d", i), 32'(q1hit), 32'd0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-side front end of the 8x16 register file: merges ALU results and late-returning load data into the register file's single write port (`writeregsel`, `writedata`, `write`). Loads have absolute priority; ALU results are buffered in a small FIFO with valid/ready backpressure. Two lookup ports give decode forwarding of every pending, not-yet-committed write.

## Interface
- `DEPTH`, 2: ALU FIFO entries (≥1).
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `alu_valid`  in  1  ALU result offered.
- `alu_ready`  out  1  FIFO can accept; `alu_ready = (count < DEPTH)`.
- `alu_reg`  in  3  ALU destination register.
- `alu_data`  in  16  ALU result.
- `ld_valid`  in  1  load data returning; cannot be stalled.
- `ld_reg`  in  3  load destination register.
- `ld_data`  in  16  load data.
- `write`  out  1  register-file write enable (registered).
- `writeregsel`  out  3  register-file write select (registered).
- `writedata`  out  16  register-file write data (registered).
- `q1sel`, `q2sel`  in  3 each  forwarding query selects.
- `q1hit`, `q2hit`  out  1 each  pending write exists for the queried register.
- `q1data`, `q2data`  out  16 each  youngest pending value; 0 when no hit.
- `err`  out  1  sticky protocol-violation flag.

## Operation
- State: an output stage (`write`, `writeregsel`, `writedata`) driving the register file, plus a DEPTH-entry ALU FIFO holding {reg, data}, with head, tail and count.
- ALU accept: `alu_valid & alu_ready`. `alu_valid` while not ready is dropped and sets `err`.
- Output-stage load each cycle, in priority order:
  - `ld_valid`: load entry.
  - else FIFO non-empty: pop head.
  - else accepted ALU with FIFO empty: ALU entry goes straight through, no FIFO write.
  - else: `write` = 0.
- FIFO push: an accepted ALU result is pushed unless it went straight through. Push and pop in the same cycle are allowed; count is unchanged.
- Full FIFO: `alu_ready` = 0 even if a pop occurs that cycle.
- Same-register hazard: a load never targets a register that has a valid FIFO entry. If `ld_valid` and `ld_reg` matches a valid FIFO entry, `err` is set and the load still takes priority.
- `err` stays 1 until reset. It is set by either violation above.
- Forwarding, per query port, combinational from stored state only (same-cycle inputs are not visible):
  - Candidates: valid FIFO entries and the output stage when `write` = 1.
  - Priority, youngest first: FIFO tail-1, …, FIFO head, output stage.
  - `qNhit` = any candidate matches; `qNdata` = youngest match's data, else 0.
- Register 0 is an ordinary register; no special casing.

## Timing
- Reset values: `write` = 0, `writeregsel` = 0, `writedata` = 0, count = 0, head = tail = 0, `err` = 0. Therefore `alu_ready` = 1, `q*hit` = 0, `q*data` = 0.
- Reset mid-operation: all pending entries are discarded immediately and nothing is written.
- Latency:
  - Load in cycle N → `write` = 1 in cycle N+1; the register file commits at the end of N+1.
  - Uncontested ALU result: same as a load.
  - ALU result queued behind k entries, with no loads arriving: appears on the port k+1 cycles after acceptance.
- Throughput: one register-file write per cycle. Back-to-back loads starve the FIFO indefinitely; that is acceptable and the issue logic bounds it.
- Pointer wrap: head and tail wrap modulo DEPTH; count is 0..DEPTH.

## Structure
- Shared package: `REG_W` = 16, `SEL_W` = 3, and a `wb_entry_t` typedef {sel[2:0], data[15:0]} for use by the pipeline stages.
- One sub-module, `wb_fifo`: parameterised on DEPTH. It exposes push, pop, full, empty, the head entry and a flat view of all entries with valid bits for the forwarding search.
- Arbitration, output stage, forwarding and `err` live in the top module.

## Test plan
- Reset, then ALU {r3, 0x1234} in cycle 1 with no load → cycle 2: `write` = 1, `writeregsel` = 3, `writedata` = 0x1234. Cycle 3: `write` = 0.
- Collision: load {r5, 0xBEEF} and ALU {r2, 0x0042} in the same cycle → next cycle writes r5/0xBEEF, the cycle after writes r2/0x0042. `q1sel` = 2 hits with 0x0042 while r2 is queued.
- Backpressure: four consecutive loads while ALU offers {r1..r4} → FIFO fills, `alu_ready` = 0 after two accepts, `err` stays 0. Drain order after the loads: r1, r2, then r3, r4 accepted and written.
- Forwarding priority: queue r6 = 0x0001 then r6 = 0x0002, with r6 = 0x0003 in the output stage → `q2sel` = 6 gives `q2hit` = 1, `q2data` = 0x0002.
- Violations: `alu_valid` while full → `err` = 1, held until reset, and the dropped value is never written. Load to a register pending in the FIFO also sets `err`.
- Asserting `rst` with two entries queued → all outputs return to their reset values immediately. After release, no write occurs.
